interrupt_sequencer: RTL and testbench

Sequences hardware interrupts and the post-reset start-up into the CPU instruction pipeline. At each opcode-fetch boundary it either passes the fetched opcode to the predecode/instruction register path, or forces BRK (0x00) so that the existing BRK microcode services the event. It also supplies the vector address and B-flag value to the datapath. It sits between the memory data bus and the instruction controller's PD input.

---
 rtl/interrupt_sequencer.sv | 105 ++++++++++
 tb/tb_interrupt_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Forces BRK into the opcode path at fetch boundaries for reset, NMI and IRQ,
// and supplies the matching vector address, B flag and stack-write inhibit.
module interrupt_sequencer #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  BRK_OPCODE  = 8'h00
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        sync,
    input  logic [7:0]  mem_data,
    input  logic        vec_ack,
    output logic [7:0]  pd_out,
    output logic        int_active,
    output logic [15:0] vec_addr,
    output logic        b_flag,
    output logic        rw_inhibit
);

    typedef enum logic {IDLE, SERVICE} state_t;
    typedef enum logic [1:0] {NONE, RESET, NMI, IRQ} src_t;

    state_t state, state_nxt;
    src_t   src, src_nxt;

    logic [SYNC_STAGES-1:0] nmi_sync, irq_sync;
    logic nmi_s, irq_s, nmi_prev;
    logic nmi_pend, nmi_pend_nxt, nmi_clr;
    logic rst_pend, rst_pend_nxt;
    logic nmi_fall, irq_req, take;

    assign nmi_s = nmi_sync[SYNC_STAGES-1];
    assign irq_s = irq_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            nmi_sync <= '1;
            irq_sync <= '1;
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
            rst_pend <= 1'b1;
            state    <= IDLE;
            src      <= NONE;
        end else begin
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
            nmi_prev <= nmi_s;
            nmi_pend <= nmi_pend_nxt;
            rst_pend <= rst_pend_nxt;
            state    <= state_nxt;
            src      <= src_nxt;
        end
    end

    always_comb begin
        nmi_fall     = nmi_prev & ~nmi_s;
        irq_req      = ~irq_s & ~i_flag;
        take         = rst_pend | nmi_pend | irq_req;
        state_nxt    = state;
        src_nxt      = src;
        rst_pend_nxt = rst_pend;
        nmi_clr      = 1'b0;

        case (state)
            IDLE: begin
                if (sync && take) begin
                    state_nxt = SERVICE;
                    if (rst_pend)      src_nxt = RESET;
                    else if (nmi_pend) src_nxt = NMI;
                    else               src_nxt = IRQ;
                end
            end
            SERVICE: begin
                if (vec_ack) begin
                    state_nxt = IDLE;
                    if (src == RESET) rst_pend_nxt = 1'b0;
                    if (src == NMI)   nmi_clr      = 1'b1;
                end else if (src == IRQ && nmi_pend) begin
                    // A pending NMI steals an IRQ sequence before its vector is read
                    src_nxt = NMI;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A fresh falling edge beats a same-cycle clear so the second NMI is not lost
        nmi_pend_nxt = nmi_fall | (nmi_pend & ~nmi_clr);

        pd_out     = (sync && state == IDLE && take) ? BRK_OPCODE : mem_data;
        int_active = (state == SERVICE);
        b_flag     = (state == IDLE);
        rw_inhibit = (state == SERVICE) && (src == RESET);
        vec_addr   = 16'hFFFE;
        if (state == SERVICE) begin
            case (src)
                RESET:   vec_addr = 16'hFFFC;
                NMI:     vec_addr = 16'hFFFA;
                default: vec_addr = 16'hFFFE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios with literal expectations,
// then random traffic, all outputs checked every cycle against a delay-line model.
module tb_interrupt_sequencer;

    localparam int         S   = 2;
    localparam logic [7:0] BRK = 8'h00;

    logic        clk_ph1 = 1'b0;
    logic        rst = 1'b0, nmi_n = 1'b1, irq_n = 1'b1, i_flag = 1'b1;
    logic        sync = 1'b0, vec_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic [7:0]  pd_out;
    logic        int_active, b_flag, rw_inhibit;
    logic [15:0] vec_addr;

    int tests = 0;
    int fails = 0;

    interrupt_sequencer #(.SYNC_STAGES(S), .BRK_OPCODE(BRK)) dut (
        .clk_ph1(clk_ph1), .rst(rst), .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
        .sync(sync), .mem_data(mem_data), .vec_ack(vec_ack), .pd_out(pd_out),
        .int_active(int_active), .vec_addr(vec_addr), .b_flag(b_flag), .rw_inhibit(rw_inhibit)
    );

    always #5 clk_ph1 = ~clk_ph1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pin histories as plain delay lines, service in progress as a vector value
    bit nmi_h[0:S];
    bit irq_h[0:S-1];
    bit m_valid = 1'b0, m_svc = 1'b0, m_rst_pend = 1'b1, m_nmi_pend = 1'b0;
    int m_vec = 'hFFFE;

    always @(posedge clk_ph1) begin
        bit fall, req, clr;
        if (!rst) begin
            for (int i = 0; i <= S; i++) nmi_h[i] = 1'b1;
            for (int i = 0; i < S; i++)  irq_h[i] = 1'b1;
            m_nmi_pend = 1'b0;
            m_rst_pend = 1'b1;
            m_svc      = 1'b0;
            m_vec      = 'hFFFE;
            m_valid    = 1'b1;
        end else begin
            fall = nmi_h[S] && !nmi_h[S-1];
            req  = !irq_h[S-1] && !i_flag;
            clr  = 1'b0;
            if (!m_svc) begin
                if (sync && (m_rst_pend || m_nmi_pend || req)) begin
                    m_svc = 1'b1;
                    m_vec = m_rst_pend ? 'hFFFC : (m_nmi_pend ? 'hFFFA : 'hFFFE);
                end
            end else if (vec_ack) begin
                m_svc = 1'b0;
                if (m_vec == 'hFFFC) m_rst_pend = 1'b0;
                if (m_vec == 'hFFFA) clr = 1'b1;
            end else if (m_vec == 'hFFFE && m_nmi_pend) begin
                m_vec = 'hFFFA;
            end
            if (fall)     m_nmi_pend = 1'b1;
            else if (clr) m_nmi_pend = 1'b0;
            for (int i = S; i > 0; i--) nmi_h[i] = nmi_h[i-1];
            nmi_h[0] = nmi_n;
            for (int i = S - 1; i > 0; i--) irq_h[i] = irq_h[i-1];
            irq_h[0] = irq_n;
        end
    end

    always @(negedge clk_ph1) begin
        bit take;
        if (m_valid) begin
            take = m_rst_pend || m_nmi_pend || (!irq_h[S-1] && !i_flag);
            chk("pd_out", {24'h0, pd_out}, {24'h0, (sync && !m_svc && take) ? BRK : mem_data});
            chk("int_active", {31'h0, int_active}, {31'h0, m_svc});
            chk("b_flag", {31'h0, b_flag}, {31'h0, !m_svc});
            chk("vec_addr", {16'h0, vec_addr}, m_svc ? m_vec : 32'hFFFE);
            chk("rw_inhibit", {31'h0, rw_inhibit}, {31'h0, m_svc && m_vec == 'hFFFC});
        end
    end

    task automatic step();
        @(posedge clk_ph1);
        #1;
    endtask

    task automatic service(input logic [15:0] v, input string nm);
        sync = 1'b1; mem_data = 8'hC5;
        #2 chk({nm, "_pd"}, {24'h0, pd_out}, 32'h00);
        step();
        sync = 1'b0; mem_data = 8'h11;
        #2 chk({nm, "_vec"}, {16'h0, vec_addr}, {16'h0, v});
        chk({nm, "_b"}, {31'h0, b_flag}, 32'h0);
        chk({nm, "_act"}, {31'h0, int_active}, 32'h1);
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        #2 chk({nm, "_done"}, {31'h0, int_active}, 32'h0);
    endtask

    initial begin
        int inj;

        // Reset values, then the start-up injection
        repeat (3) step();
        #2 chk("rst_act", {31'h0, int_active}, 32'h0);
        chk("rst_rw", {31'h0, rw_inhibit}, 32'h0);
        chk("rst_b", {31'h0, b_flag}, 32'h1);
        chk("rst_vec", {16'h0, vec_addr}, 32'hFFFE);
        rst = 1'b1; sync = 1'b1; mem_data = 8'hA9;
        #2 chk("boot_pd", {24'h0, pd_out}, 32'h00);
        step();
        sync = 1'b0;
        #2 chk("boot_act", {31'h0, int_active}, 32'h1);
        chk("boot_rw", {31'h0, rw_inhibit}, 32'h1);
        chk("boot_vec", {16'h0, vec_addr}, 32'hFFFC);
        vec_ack = 1'b1;
        step();
        vec_ack = 1'b0; sync = 1'b1; mem_data = 8'hA9;
        #2 chk("boot_pass", {24'h0, pd_out}, 32'hA9);
        chk("boot_rw_off", {31'h0, rw_inhibit}, 32'h0);
        step();
        sync = 1'b0;

        // NMI pulse: not visible after two edges, injected after the third
        nmi_n = 1'b0;
        step();
        nmi_n = 1'b1;
        step();
        sync = 1'b1; mem_data = 8'hEA;
        #2 chk("nmi_early", {24'h0, pd_out}, 32'hEA);
        step();
        service(16'hFFFA, "nmi");

        // Held-low NMI gives exactly one service
        inj = 0;
        nmi_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) nmi_n = 1'b1;
            sync = 1'b1; mem_data = 8'hEA;
            vec_ack = int_active;
            #2 if (pd_out == 8'h00) inj++;
            step();
        end
        sync = 1'b0; vec_ack = 1'b0;
        chk("nmi_hold_count", inj, 1);

        // IRQ masked, then unmasked, then level-retriggered
        irq_n = 1'b0; i_flag = 1'b1;
        repeat (3) step();
        sync = 1'b1; mem_data = 8'h58;
        #2 chk("irq_masked", {24'h0, pd_out}, 32'h58);
        step();
        sync = 1'b0; i_flag = 1'b0;
        service(16'hFFFE, "irq");
        service(16'hFFFE, "irq_again");

        // NMI hijacks an IRQ sequence before vec_ack
        sync = 1'b1; mem_data = 8'hC5;
        step();
        sync = 1'b0; nmi_n = 1'b0;
        step();
        nmi_n = 1'b1;
        step();
        #2 chk("hijack_before", {16'h0, vec_addr}, 32'hFFFE);
        step();
        step();
        #2 chk("hijack_vec", {16'h0, vec_addr}, 32'hFFFA);
        chk("hijack_b", {31'h0, b_flag}, 32'h0);
        irq_n = 1'b1; i_flag = 1'b1; vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        #2 chk("hijack_done", {31'h0, int_active}, 32'h0);
        step();
        step();
        sync = 1'b1; mem_data = 8'h58;
        #2 chk("hijack_cleared", {24'h0, pd_out}, 32'h58);
        step();
        sync = 1'b0;

        // All three sources at once are serviced in priority order
        rst = 1'b0;
        step();
        step();
        rst = 1'b1; nmi_n = 1'b0; irq_n = 1'b0; i_flag = 1'b0;
        step();
        nmi_n = 1'b1;
        step();
        step();
        service(16'hFFFC, "pri_rst");
        service(16'hFFFA, "pri_nmi");
        service(16'hFFFE, "pri_irq");
        irq_n = 1'b1; i_flag = 1'b1;

        // Software BRK passes through with B=1 and an idle vec_ack is ignored
        repeat (3) step();
        sync = 1'b1; mem_data = 8'h00;
        #2 chk("swbrk_pd", {24'h0, pd_out}, 32'h00);
        chk("swbrk_act", {31'h0, int_active}, 32'h0);
        chk("swbrk_b", {31'h0, b_flag}, 32'h1);
        chk("swbrk_vec", {16'h0, vec_addr}, 32'hFFFE);
        step();
        sync = 1'b0; vec_ack = 1'b1;
        step();
        vec_ack = 1'b0;
        #2 chk("swbrk_ack_act", {31'h0, int_active}, 32'h0);
        chk("swbrk_ack_b", {31'h0, b_flag}, 32'h1);
        sync = 1'b1; mem_data = 8'hA9;
        #2 chk("swbrk_after", {24'h0, pd_out}, 32'hA9);
        step();

        // Random traffic, including mid-sequence resets
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 5) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 7) == 0) i_flag = ~i_flag;
            sync     = ($urandom_range(0, 3) == 0);
            vec_ack  = ($urandom_range(0, 4) == 0);
            mem_data = 8'($urandom);
            step();
        end
        rst = 1'b1; sync = 1'b0; vec_ack = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
